// File: rtl/ucode_seq.sv
// Microcode sequencer: computes the next micro-address for an external synchronous ROM.
// Optional NMI input and logic are enabled by defining UCODE_NMI_EN.
module ucode_seq #(
    parameter int              DW        = 8,
    parameter int              AW        = 9,
    parameter int              CW        = 32,
    parameter int              FW        = 5,
    parameter int              SD        = 4,
    parameter logic [AW-1:0]   RESET_VEC = 9'h160,
    parameter logic [AW-1:0]   IRQ_VEC   = 9'h168,
    parameter logic [AW-1:0]   NMI_VEC   = 9'h170,
    parameter logic [AW-1:0]   FIN_BASE  = 9'h140
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [AW-1:0] uaddr,
    input  logic [CW-1:0] uword,
    input  logic [DW-1:0] DB,
    input  logic          rdy,
    input  logic          cond,
    input  logic          irq,
    input  logic          I,
`ifdef UCODE_NMI_EN
    input  logic          nmi,
`endif
    output logic          sync,
    output logic          err
);

    localparam int IW  = $clog2(SD);
    localparam int SPW = IW + 1;

    typedef enum logic [2:0] {
        SEQ_DECODE = 3'b000,
        SEQ_NEXT   = 3'b001,
        SEQ_FINISH = 3'b010,
        SEQ_SAVE   = 3'b011,
        SEQ_CALL   = 3'b100,
        SEQ_RET    = 3'b101,
        SEQ_BRANCH = 3'b110,
        SEQ_WAIT   = 3'b111
    } seq_e;

    seq_e            seq;
    logic [AW-2:0]   tgt;
    logic [FW-1:0]   fin;
    logic [AW-1:0]   jump_addr;
    logic [AW-1:0]   uaddr_q;
    logic [AW-1:0]   uaddr_inc;
    logic [AW-1:0]   seq_addr;
    logic [FW-1:0]   finish;
    logic [AW-1:0]   stack [SD];
    logic [SPW-1:0]  sp;
    logic [SPW-1:0]  sp_dec;
    logic            stack_full;
    logic            stack_empty;
    logic            push;
    logic            pop;
    logic            nmi_take;
    logic            nmi_pend;
    logic            unused_bits;

    assign seq         = seq_e'(uword[CW-1:CW-3]);
    assign tgt         = uword[AW-2:0];
    assign fin         = uword[AW+FW-2:AW-1];
    assign unused_bits = ^uword[CW-4:AW+FW-1];
    assign jump_addr   = {1'b1, tgt};
    assign uaddr_inc   = uaddr_q + 1'b1;
    assign sp_dec      = sp - 1'b1;
    assign stack_full  = (sp == SPW'(SD));
    assign stack_empty = (sp == '0);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        seq_addr = uaddr_q;
        push     = 1'b0;
        pop      = 1'b0;
        nmi_take = 1'b0;
        case (seq)
            SEQ_DECODE: begin
                if (nmi_pend) begin
                    seq_addr = NMI_VEC;
                    nmi_take = 1'b1;
                end else if (irq && !I) begin
                    seq_addr = IRQ_VEC;
                end else begin
                    seq_addr = {{(AW-DW){1'b0}}, DB};
                end
            end
            SEQ_NEXT, SEQ_SAVE: seq_addr = jump_addr;
            SEQ_FINISH:         seq_addr = FIN_BASE | AW'(finish);
            SEQ_CALL: begin
                push     = 1'b1;
                seq_addr = jump_addr;
            end
            SEQ_RET: begin
                pop      = 1'b1;
                seq_addr = stack_empty ? RESET_VEC : stack[sp_dec[IW-1:0]];
            end
            SEQ_BRANCH: seq_addr = cond ? jump_addr : uaddr_inc;
            SEQ_WAIT:   seq_addr = (irq || nmi_pend) ? jump_addr : uaddr_q;
            default:    seq_addr = uaddr_q;
        endcase
    end

    // A stalled cycle re-presents the address of the word currently held by the ROM.
    assign uaddr = !reset_n ? RESET_VEC : (rdy ? seq_addr : uaddr_q);
    assign sync  = reset_n && (seq == SEQ_DECODE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uaddr_q <= RESET_VEC;
            finish  <= '0;
            sp      <= '0;
            err     <= 1'b0;
        end else begin
            if ((push && stack_full) || (pop && stack_empty))
                err <= 1'b1;
            if (rdy) begin
                uaddr_q <= seq_addr;
                if (seq == SEQ_SAVE)
                    finish <= fin;
                if (push && !stack_full)
                    sp <= sp + 1'b1;
                else if (pop && !stack_empty)
                    sp <= sp_dec;
            end
        end
    end

    // NOTE: stack storage has no reset; entries above the depth pointer are never read.
    always_ff @(posedge clk) begin
        if (reset_n && rdy && push && !stack_full)
            stack[sp[IW-1:0]] <= uaddr_inc;
    end

`ifdef UCODE_NMI_EN
    logic nmi_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_prev <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            nmi_prev <= nmi;
            nmi_pend <= (nmi_pend && !(rdy && nmi_take)) || (nmi && !nmi_prev);
        end
    end
`else
    logic unused_nmi;

    assign nmi_pend   = 1'b0;
    assign unused_nmi = nmi_take;
`endif

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq: ROM model, linear step sequence, scoreboard of expected outputs.
// Define UCODE_NMI_EN to also exercise the NMI path.
module tb_ucode_seq;

    logic        clk;
    logic        reset_n;
    logic [8:0]  uaddr;
    logic [31:0] uword;
    logic [7:0]  DB;
    logic        rdy;
    logic        cond;
    logic        irq;
    logic        I;
`ifdef UCODE_NMI_EN
    logic        nmi;
`endif
    logic        sync;
    logic        err;

    logic [31:0] rom [512];

    typedef struct packed {
        logic [8:0] addr;
        logic       sync;
        logic       err;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    checks;
    int    errors;

    ucode_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .uaddr   (uaddr),
        .uword   (uword),
        .DB      (DB),
        .rdy     (rdy),
        .cond    (cond),
        .irq     (irq),
        .I       (I),
`ifdef UCODE_NMI_EN
        .nmi     (nmi),
`endif
        .sync    (sync),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: uword holds the word for last cycle's uaddr.
    always @(posedge clk) uword <= rom[uaddr];

    function automatic logic [31:0] mk(input logic [2:0] s, input logic [4:0] f, input logic [7:0] t);
        return {s, 16'h0000, f, t};
    endfunction

    task automatic compare_pop();
        exp_t  e;
        string t;
        if (exp_q.size() == 0 || tag_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (uaddr === e.addr) else begin
                errors++;
                $error("FAIL %s uaddr: got %h expected %h", t, uaddr, e.addr);
            end
            checks++;
            assert (sync === e.sync) else begin
                errors++;
                $error("FAIL %s sync: got %b expected %b", t, sync, e.sync);
            end
            checks++;
            assert (err === e.err) else begin
                errors++;
                $error("FAIL %s err: got %b expected %b", t, err, e.err);
            end
        end
    endtask

    // One cycle: drive inputs just after the falling edge, check mid-cycle, advance.
    task automatic step(input string tag, input logic r, input logic [7:0] db, input logic c,
                        input logic iq, input logic im,
                        input logic [8:0] ea, input logic es, input logic ee);
        exp_t e;
        rdy  = r;
        DB   = db;
        cond = c;
        irq  = iq;
        I    = im;
        e.addr = ea;
        e.sync = es;
        e.err  = ee;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        compare_pop();
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        rdy     = 1'b1;
        DB      = 8'h00;
        cond    = 1'b0;
        irq     = 1'b0;
        I       = 1'b0;
`ifdef UCODE_NMI_EN
        nmi     = 1'b0;
`endif
        for (int i = 0; i < 512; i++) rom[i] = 32'h0;

        rom[9'h160] = mk(3'b000, 5'h00, 8'h00);  // DECODE
        rom[9'h0A9] = mk(3'b011, 5'h03, 8'h10);  // SAVE
        rom[9'h110] = mk(3'b010, 5'h00, 8'h00);  // FINISH
        rom[9'h143] = mk(3'b100, 5'h00, 8'h50);  // CALL chain
        rom[9'h150] = mk(3'b100, 5'h00, 8'h52);
        rom[9'h152] = mk(3'b100, 5'h00, 8'h54);
        rom[9'h154] = mk(3'b100, 5'h00, 8'h56);
        rom[9'h156] = mk(3'b100, 5'h00, 8'h58);
        rom[9'h158] = mk(3'b101, 5'h00, 8'h00);  // RET chain
        rom[9'h155] = mk(3'b101, 5'h00, 8'h00);
        rom[9'h153] = mk(3'b101, 5'h00, 8'h00);
        rom[9'h151] = mk(3'b101, 5'h00, 8'h00);
        rom[9'h144] = mk(3'b101, 5'h00, 8'h00);
        rom[9'h05A] = mk(3'b001, 5'h00, 8'h60);  // NEXT -> 160
        rom[9'h168] = mk(3'b111, 5'h00, 8'h70);  // WAIT
        rom[9'h170] = mk(3'b110, 5'h00, 8'h7F);  // BRANCH
        rom[9'h17F] = mk(3'b001, 5'h00, 8'hFF);  // NEXT -> 1FF
        rom[9'h1FF] = mk(3'b110, 5'h00, 8'h00);  // BRANCH wrap
        rom[9'h000] = mk(3'b011, 5'h07, 8'h80);  // SAVE
        rom[9'h180] = mk(3'b100, 5'h00, 8'h90);  // CALL
        rom[9'h190] = mk(3'b101, 5'h00, 8'h00);  // RET
        rom[9'h181] = mk(3'b010, 5'h00, 8'h00);  // FINISH
        rom[9'h147] = mk(3'b110, 5'h00, 8'hA0);  // BRANCH
        rom[9'h1A0] = mk(3'b101, 5'h00, 8'h00);  // RET, empty stack
        rom[9'h171] = mk(3'b001, 5'h00, 8'h60);  // NEXT -> 160

        repeat (3) @(negedge clk);
        step("in_reset",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h160, 1'b0, 1'b0);
        reset_n = 1'b1;
        step("decode_a9",   1'b1, 8'hA9, 1'b0, 1'b0, 1'b0, 9'h0A9, 1'b1, 1'b0);
        step("save",        1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h110, 1'b0, 1'b0);
        step("finish3",     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h143, 1'b0, 1'b0);
        step("call1",       1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h150, 1'b0, 1'b0);
        step("call2",       1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h152, 1'b0, 1'b0);
        step("call3",       1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h154, 1'b0, 1'b0);
        step("call4",       1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h156, 1'b0, 1'b0);
        step("call5_ovf",   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h158, 1'b0, 1'b0);
        step("ret1",        1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h155, 1'b0, 1'b1);
        step("ret2",        1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h153, 1'b0, 1'b1);
        step("ret3",        1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h151, 1'b0, 1'b1);
        step("ret4",        1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h144, 1'b0, 1'b1);
        step("ret5_unf",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h160, 1'b0, 1'b1);
        step("dec_masked",  1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 9'h05A, 1'b1, 1'b1);
        step("next_160",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h160, 1'b0, 1'b1);
        step("dec_irq",     1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 9'h168, 1'b1, 1'b1);
        step("wait_a",      1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 9'h168, 1'b0, 1'b1);
        step("wait_b",      1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 9'h168, 1'b0, 1'b1);
        step("wait_wake",   1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 9'h170, 1'b0, 1'b1);
        step("br_taken",    1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 9'h17F, 1'b0, 1'b1);
        step("next_1ff",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h1FF, 1'b0, 1'b1);
        step("br_wrap",     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("stall_save", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        step("save7",       1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h180, 1'b0, 1'b1);
        step("call_190",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h190, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("stall_ret", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h190, 1'b0, 1'b1);
        step("ret_181",     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h181, 1'b0, 1'b1);
        step("finish7",     1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h147, 1'b0, 1'b1);
        step("br_1a0",      1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 9'h1A0, 1'b0, 1'b1);
`ifdef UCODE_NMI_EN
        nmi = 1'b1;
`endif
        step("ret_empty",   1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 9'h160, 1'b0, 1'b1);
`ifdef UCODE_NMI_EN
        step("dec_nmi",     1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 9'h170, 1'b1, 1'b1);
        step("br_not",      1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 9'h171, 1'b0, 1'b1);
        step("next_dec",    1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 9'h160, 1'b0, 1'b1);
        step("dec_irq2",    1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 9'h168, 1'b1, 1'b1);
`else
        step("dec_irq2",    1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 9'h168, 1'b1, 1'b1);
`endif

        // Mid-WAIT reset assertion away from any clock edge must take effect at once.
        rdy = 1'b1;
        irq = 1'b0;
        #3;
        reset_n = 1'b0;
        e.addr = 9'h160;
        e.sync = 1'b0;
        e.err  = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back("async_reset");
        #1;
        compare_pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucode_seq.md
UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 Parameters: DW, default 8, opcode/data-bus width; AW, default 9, micro-address width (AW > DW); CW, default 32, control word width; FW, default 5, finisher index width; SD, default 4, call stack depth (power of 2, >=2).
REQ-002 Parameters: RESET_VEC, default 9'h160, reset micro-address; IRQ_VEC, default 9'h168, IRQ micro-address; NMI_VEC, default 9'h170, NMI micro-address; FIN_BASE, default 9'h140, finisher area base.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 uaddr  out  AW  micro-address presented to the external synchronous microcode ROM.
REQ-006 uword  in  CW  ROM data for the uaddr of the previous cycle.
REQ-007 DB  in  DW  data bus; supplies the opcode in decode cycles.
REQ-008 rdy  in  1  1 = advance, 0 = stall.
REQ-009 cond  in  1  branch condition from datapath.
REQ-010 irq  in  1  level interrupt request; I  in  1  interrupt mask flag.
REQ-011 nmi  in  1  NMI input (present only with UCODE_NMI_EN).
REQ-012 sync  out  1  current word is a decode word.
REQ-013 err  out  1  sticky stack overflow/underflow flag.

Function
REQ-014 Fields: seq = uword[CW-1:CW-3]; tgt = uword[AW-2:0]; fin = uword[AW+FW-2:AW-1].
REQ-015 uaddr is combinational from uword and state; uaddr_q registers the uaddr of the last advancing cycle.
REQ-016 seq 000 DECODE: NMI pending -> NMI_VEC; else irq&~I -> IRQ_VEC; else {0,DB}; sync=1 only for this code.
REQ-017 seq 001 NEXT: uaddr = {1,tgt}.
REQ-018 seq 010 FINISH: uaddr = FIN_BASE | finish, finish zero-extended.
REQ-019 seq 011 SAVE: uaddr = {1,tgt}; finish <= fin at the clock edge.
REQ-020 seq 100 CALL: push uaddr_q+1 (mod 2^AW); uaddr = {1,tgt}.
REQ-021 seq 101 RET: pop; uaddr = popped value.
REQ-022 seq 110 BRANCH: cond=1 -> {1,tgt}; else uaddr_q+1 (mod 2^AW).
REQ-023 seq 111 WAIT: uaddr = uaddr_q until irq=1 (regardless of I) or NMI pending; then uaddr = {1,tgt}.
REQ-024 rdy=0: uaddr = uaddr_q; no register (finish, stack, uaddr_q, NMI latch clear) updates; err and NMI edge capture still update.
REQ-025 Stack: SD entries, pointer depth 0..SD; push at depth SD -> push dropped, err<=1; pop at depth 0 -> uaddr = RESET_VEC, err<=1.
REQ-026 CALL and RET never occur in one cycle; SAVE does not touch the stack.
REQ-027 err clears only on reset.

Reset
REQ-028 While reset_n=0: uaddr = RESET_VEC, uaddr_q = RESET_VEC, finish = 0, stack depth = 0, err = 0, NMI pending = 0, sync = 0.
REQ-029 First uword after reset_n release is the word at RESET_VEC; the first edge with reset_n=1 begins normal sequencing.
REQ-030 Reset assertion mid-CALL, mid-WAIT or mid-stall aborts immediately and asynchronously; no partial state survives.

Configuration
REQ-031 Macro UCODE_NMI_EN: defined -> nmi port present; rising edge (registered previous value) sets NMI pending; pending cleared in the advancing cycle that selects NMI_VEC; NMI outranks IRQ and ignores I.
REQ-032 UCODE_NMI_EN undefined -> no nmi port, no NMI logic; NMI_VEC unused; DECODE/WAIT consider irq only.

Verification
REQ-033 Release reset, ROM word at 9'h160 = DECODE, DB=8'hA9, irq=0 -> uaddr=9'h0A9, sync=1.
REQ-034 SAVE tgt=8'h10 fin=5'h03, then FINISH -> uaddr=9'h110, then 9'h143.
REQ-035 Five CALLs with SD=4 -> 5th push dropped, err=1; five RETs -> 4 correct returns, 5th gives 9'h160.
REQ-036 DECODE with irq=1, I=1 -> {0,DB}; with irq=1, I=0 -> 9'h168; WAIT with I=1, irq pulsed -> resumes at {1,tgt}.
REQ-037 BRANCH at uaddr_q=9'h1FF, cond=0 -> uaddr=9'h000 (wrap); rdy=0 for 3 cycles -> uaddr holds, finish unchanged.
REQ-038 UCODE_NMI_EN: nmi rising edge with irq=1, I=0 at DECODE -> 9'h170 once; next DECODE -> 9'h168.
